// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, twiddle-sequencer modes and the
// generator for the plain-form zeta table (zeta[k] = 17^bitrev7(k) mod q).
package kyber_pkg;

  localparam int KYBER_Q  = 3329;
  localparam int KYBER_QW = 12;
  localparam int KYBER_N  = 256;
  localparam int ZETA_N   = KYBER_N / 2;

  typedef enum logic [1:0] {
    TF_NTT     = 2'd0,
    TF_INTT    = 2'd1,
    TF_BASEMUL = 2'd2
  } tf_mode_t;

  typedef logic [ZETA_N-1:0][KYBER_QW-1:0] zeta_tab_t;

  function automatic logic [6:0] bitrev7(input logic [6:0] k);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = k[6-i];
    return r;
  endfunction

  // Elaboration-time table build; repeated multiply keeps it obviously correct.
  function automatic zeta_tab_t gen_zetas(input int q);
    zeta_tab_t t;
    int        acc;
    t = '0;
    for (int k = 0; k < ZETA_N; k++) begin
      acc = 1;
      for (int e = 0; e < int'(bitrev7(7'(k))); e++) acc = (acc * 17) % q;
      t[k] = KYBER_QW'(acc);
    end
    return t;
  endfunction

  // Beats each zeta index is held for: max(1, (128 >> layer) / bf), bf in {1,2}.
  function automatic int beats_per_index(input logic [2:0] layer, input int bf);
    int n;
    n = (128 >> layer) >> (bf - 1);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/zeta_rom.sv
// zeta_rom: 128 x Q_W synchronous twiddle ROM, 1-cycle read latency.
// The optional negate input folds (KQ - zeta) mod KQ into the read register.
module zeta_rom
  import kyber_pkg::*;
#(
  parameter int Q_W = KYBER_QW,
  parameter int KQ  = KYBER_Q
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           neg,
  input  logic [6:0]     addr,
  output logic [Q_W-1:0] data
);

  localparam zeta_tab_t TABLE = gen_zetas(KQ);

  logic [Q_W-1:0] word;
  logic [Q_W-1:0] word_out;

  // Table lookup and optional modular negation ahead of the read register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    word     = Q_W'(TABLE[addr]);
    word_out = word;
    if (neg && (word != '0)) word_out = Q_W'(KQ) - word;
  end

  // Read register: holds its value whenever the pipeline stalls.
  always_ff @(posedge clk) begin
    // NOTE: only the read register is reset; the table is a constant and needs no reset.
    if (rst)     data <= '0;
    else if (en) data <= word_out;
  end

endmodule

// File: rtl/tf_seq_gen.sv
// tf_seq_gen: self-addressing Kyber twiddle-factor sequencer.
// Walks the zeta table in NTT / INTT / BASEMUL order, repeating each factor
// for the beats the butterfly array consumes it, over a valid/ready stream.
// Optional macro TF_SEQ_INV_NEG_EN: output (KQ - zeta) mod KQ in INTT mode.
module tf_seq_gen
  import kyber_pkg::*;
#(
  parameter int Q_W = KYBER_QW,
  parameter int KQ  = KYBER_Q,
  parameter int BF  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  output logic           busy,
  output logic           tf_valid,
  input  logic           tf_ready,
  output logic [Q_W-1:0] tf_data,
  output logic [2:0]     tf_layer,
  output logic           tf_first,
  output logic           tf_last,
  output logic           done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t     state;
  tf_mode_t   mode_q;
  logic [2:0] layer;
  logic [6:0] idx;
  logic [7:0] rep;

  logic [7:0] lay_bit;
  logic [7:0] rep_max;
  logic       last_rep;
  logic       final_addr;
  logic       adv;

  // Address stage: registered ROM address plus the beat's sideband.
  logic       a_valid;
  logic [6:0] a_addr;
  logic [2:0] a_layer;
  logic       a_first;
  logic       a_last;
  logic       rom_neg;

  // Both pipeline stages move together; tf_ready only reaches enables.
  assign adv = !tf_valid || tf_ready;

  // Repeat length for the current index and detection of the final address.
  always_comb begin
    lay_bit    = 8'd1 << layer;
    rep_max    = (mode_q == TF_BASEMUL) ? 8'd0 : 8'(beats_per_index(layer, BF) - 1);
    last_rep   = (rep == rep_max);
    final_addr = last_rep && ((mode_q == TF_INTT) ? (idx == 7'd1) : (idx == 7'd127));
  end

  // Control FSM with layer / index / repeat counters and registered busy/done.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= TF_NTT;
      layer  <= '0;
      idx    <= '0;
      rep    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (mode != 2'd3)) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            mode_q <= tf_mode_t'(mode);
            rep    <= '0;
            case (mode)
              2'd1:    begin layer <= 3'd6; idx <= 7'd127; end
              2'd2:    begin layer <= 3'd6; idx <= 7'd64;  end
              default: begin layer <= 3'd0; idx <= 7'd1;   end
            endcase
          end
        end
        S_RUN: begin
          if (adv) begin
            if (final_addr) begin
              state <= S_DRAIN;
            end else if (!last_rep) begin
              rep <= rep + 8'd1;
            end else begin
              rep <= '0;
              case (mode_q)
                TF_INTT: begin
                  idx <= idx - 7'd1;
                  if (idx == lay_bit[6:0]) layer <= layer - 3'd1;
                end
                TF_NTT: begin
                  idx <= idx + 7'd1;
                  if (idx == 7'((lay_bit << 1) - 8'd1)) layer <= layer + 3'd1;
                end
                default: idx <= idx + 7'd1;
              endcase
            end
          end
        end
        S_DRAIN: begin
          if (tf_valid && tf_ready && tf_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address stage: one ROM address issued per advance while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_layer <= '0;
      a_first <= 1'b0;
      a_last  <= 1'b0;
    end else if (adv) begin
      a_valid <= (state == S_RUN);
      a_addr  <= idx;
      a_layer <= layer;
      a_first <= (state == S_RUN) && (rep == 8'd0);
      a_last  <= (state == S_RUN) && final_addr;
    end
  end

  // Output stage: sideband travels alongside the ROM read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tf_valid <= 1'b0;
      tf_layer <= '0;
      tf_first <= 1'b0;
      tf_last  <= 1'b0;
    end else if (adv) begin
      tf_valid <= a_valid;
      tf_layer <= a_layer;
      tf_first <= a_first;
      tf_last  <= a_last;
    end
  end

`ifdef TF_SEQ_INV_NEG_EN
  logic a_neg;

  // Negate flag rides in the address stage so the ROM register applies it.
  always_ff @(posedge clk) begin
    if (rst)      a_neg <= 1'b0;
    else if (adv) a_neg <= (mode_q == TF_INTT);
  end

  assign rom_neg = a_neg;
`else
  assign rom_neg = 1'b0;
`endif

  zeta_rom #(
    .Q_W (Q_W),
    .KQ  (KQ)
  ) u_zeta_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .neg  (rom_neg),
    .addr (a_addr),
    .data (tf_data)
  );

endmodule

// File: doc/tf_seq_gen.md
# tf_seq_gen

Twiddle-factor sequencer for the Kyber NTT datapath. It replaces a bare address-in/data-out zeta ROM with a self-addressing generator. On `start` it walks the zeta table in the order required by forward NTT, inverse NTT or base multiplication, and repeats each factor for as many beats as the butterfly array consumes it. It streams the factors to the butterfly unit over a valid/ready handshake, so the controller only issues a mode and a start pulse.

## Interface
- `Q_W`, 12: coefficient/twiddle width.
- `KQ`, 3329: modulus.
- `BF`, 1: butterflies per beat; legal values 1 or 2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. Synchronous, active-high. One clock; reset is synchronous and active-high.
- `start` in 1: begin a sequence. Sampled only in IDLE.
- `mode` in 2: 0 = NTT, 1 = INTT, 2 = BASEMUL, 3 = reserved.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `tf_valid` out 1: output beat valid.
- `tf_ready` in 1: consumer accepts the beat when `tf_valid && tf_ready`.
- `tf_data` out Q_W: twiddle factor.
- `tf_layer` out 3: NTT layer of the current beat (0 = len 128).
- `tf_first` out 1: first beat of a new zeta index.
- `tf_last` out 1: final beat of the sequence.
- `done` out 1: one-cycle pulse after the last beat is accepted.

## Operation
- **Zeta table.** Entry `zeta[k] = 17^bitrev7(k) mod KQ` in plain (non-Montgomery) form, k = 0..127.
- **NTT.** Layer l runs 0..6. Index k runs ascending from 2^l to 2^(l+1)-1. Each k is emitted `max(1, (128>>l)/BF)` beats. Total beats: 896/BF.
- **INTT.** Layer l runs 6 down to 0. Index k runs descending from 2^(l+1)-1 to 2^l. Per-k repeat count is the same as NTT. Total beats: 896/BF.
- **BASEMUL.** k runs 64..127, one beat each. `tf_layer` = 6. Total beats: 64.
- **States.**
  - IDLE → RUN on `start` with mode ≠ 3. Mode 3 is ignored and the block stays in IDLE.
  - RUN issues one ROM read per advance. After the final address is issued it moves to DRAIN.
  - DRAIN → DONE when the `tf_last` beat is accepted.
  - DONE → IDLE after one cycle; `done` = 1 in that cycle.
- **Counters.** Three counters: layer, index and repeat. All advance only when the pipeline advances.
- **Pipeline advance.** The pipeline advances when `!tf_valid || tf_ready`. When it stalls, the ROM enable and the address are held, so the output stays stable.
- **Sideband.** `tf_first`, `tf_last` and `tf_layer` travel in the same pipeline stage as the data.
- **start while busy.** Ignored.
- **Reset mid-operation.** Returns to IDLE. All counters are cleared. `tf_valid` is 0 in the cycle after `rst`. No `done` is produced.
- **Reset values.** Every output resets to 0.

## Timing
- Start accepted at edge 0. The first ROM address is registered at edge 1. `tf_valid` = 1 after edge 2, so first-beat latency is 2 cycles.
- With `tf_ready` held high, one beat is issued per cycle with no bubbles.
- The ROM has 1-cycle synchronous read latency. There is no combinational path from `start` to `tf_valid`.
- `tf_ready` combinationally gates only the ROM enable and the counter enables. There is no path from `tf_ready` to `tf_valid` or `tf_data`.
- `done` is asserted the cycle after the `tf_last` handshake. `busy` falls in that same cycle.

## Configuration
- `TF_SEQ_INV_NEG_EN`
  - Defined: in INTT mode the block outputs `(KQ - zeta[k]) mod KQ`, so entry 0 maps to 0. A registered subtractor sits in the output stage without adding latency.
  - Undefined: INTT outputs raw `zeta[k]`, and negation is left to the butterfly.
  - NTT and BASEMUL are unaffected in both cases.

## Structure
- **`kyber_pkg`** holds:
  - `KYBER_Q`, `KYBER_QW`, `KYBER_N`.
  - The `tf_mode_t` enum (NTT / INTT / BASEMUL).
  - The 128-entry zeta constant array, or its generator function.
- **`zeta_rom`** is one sub-module:
  - 128×Q_W synchronous ROM with read enable, 7-bit address, 1-cycle latency.
  - It is the only place the table is instantiated.

## Test plan
- **NTT, BF=1, ready=1.** Expect 896 beats.
  - Beats 0–127 = 1729 (layer 0).
  - Beats 128–191 = 2580; beats 192–255 = 3289.
  - `tf_first` on beats 0, 128, 192.
  - `tf_last` on beat 895; `done` one cycle later.
- **INTT, BF=1, TF_SEQ_INV_NEG_EN defined.** Expect layer 6 first.
  - k=127 on beats 0–1.
  - k=64 on beats 126–127 with data 3312.
  - Same run without the macro: data 17 on those beats.
- **Backpressure.** Deassert `tf_ready` for 5 cycles at beat 3.
  - `tf_data`, `tf_valid` and sideband stay constant.
  - 896 total beats, sequence unchanged.
- **BASEMUL.** Expect 64 beats: beat 0 = 17, beat 1 = 2761, `tf_last` on beat 63.
- **start while busy; reset mid-run.**
  - A `start` with mode=1 during an NTT run does not alter the sequence.
  - `rst` at beat 300 gives `tf_valid` = 0 and `busy` = 0 next cycle.
  - A following NTT start restarts at 1729.
- **BF=2.** Expect 448 beats: layer 0 = 64 beats of 1729, and layer 6 emits exactly one beat per k.
